// File: rtl/l2_slice_assoc.sv
// Set-associative, write-back, write-allocate L2 slice with one outstanding miss.
// Full-line accesses only; dirty victims are written back before refill/install.
module l2_slice_assoc #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned NUM_SETS   = 256,
    parameter int unsigned WAYS       = 4,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_rw,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_rw,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,
    output logic [CNT_WIDTH-1:0]  hit_cnt,
    output logic [CNT_WIDTH-1:0]  miss_cnt,
    output logic [CNT_WIDTH-1:0]  wb_cnt
);
    localparam int unsigned OFF = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IDX = $clog2(NUM_SETS);
    localparam int unsigned TAG = ADDR_WIDTH - IDX - OFF;
    localparam int unsigned WW  = $clog2(WAYS);

    typedef enum logic [2:0] {StIdle, StLookup, StWb, StFetch, StWait, StInstall} state_e;
    state_e state_q, state_d;

    logic [TAG-1:0]        tag_mem  [NUM_SETS][WAYS];
    logic [DATA_WIDTH-1:0] data_mem [NUM_SETS][WAYS];
    logic [WAYS-1:0]       valid_q  [NUM_SETS];
    logic [WAYS-1:0]       dirty_q  [NUM_SETS];
    logic [WW-1:0]         vptr_q   [NUM_SETS];

    logic [TAG-1:0]        req_tag_q;
    logic [IDX-1:0]        req_idx_q;
    logic                  req_rw_q;
    logic [DATA_WIDTH-1:0] req_wdata_q;
    logic [WW-1:0]         victim_q;
    logic                  victim_valid_q;
    logic [DATA_WIDTH-1:0] fill_q;
    logic                  ready_q;
    logic                  resp_valid_q;
    logic [DATA_WIDTH-1:0] resp_data_q;
    logic [ADDR_WIDTH-1:0] mem_req_addr_q;
    logic [DATA_WIDTH-1:0] mem_req_wdata_q;
    logic [CNT_WIDTH-1:0]  hit_cnt_q, miss_cnt_q, wb_cnt_q;

    logic          hit, free_found, victim_dirty;
    logic [WW-1:0] hit_way, free_way, victim_way;
    logic          unused_offset;

    assign unused_offset = ^req_addr[OFF-1:0];

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        free_found = 1'b0;
        free_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx_q][w] && tag_mem[req_idx_q][w] == req_tag_q) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
            if (!valid_q[req_idx_q][w] && !free_found) begin
                free_found = 1'b1;
                free_way   = WW'(w);
            end
        end
        victim_way   = free_found ? free_way : vptr_q[req_idx_q];
        victim_dirty = valid_q[req_idx_q][victim_way] && dirty_q[req_idx_q][victim_way];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (req_valid && req_ready) state_d = StLookup;
            StLookup: begin
                if (hit)               state_d = StIdle;
                else if (victim_dirty) state_d = StWb;
                else if (req_rw_q)     state_d = StInstall;
                else                   state_d = StFetch;
            end
            StWb:      if (mem_req_ready) state_d = req_rw_q ? StInstall : StFetch;
            StFetch:   if (mem_req_ready) state_d = StWait;
            StWait:    if (mem_resp_valid) state_d = StInstall;
            StInstall: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    assign req_ready     = ready_q && (state_q == StIdle);
    assign mem_req_valid = (state_q == StWb) || (state_q == StFetch);
    assign mem_req_rw    = (state_q == StWb);
    assign mem_req_addr  = mem_req_addr_q;
    assign mem_req_wdata = mem_req_wdata_q;
    assign resp_valid    = resp_valid_q;
    assign resp_data     = resp_data_q;
    assign hit_cnt       = hit_cnt_q;
    assign miss_cnt      = miss_cnt_q;
    assign wb_cnt        = wb_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            ready_q         <= 1'b0;
            req_tag_q       <= '0;
            req_idx_q       <= '0;
            req_rw_q        <= 1'b0;
            req_wdata_q     <= '0;
            victim_q        <= '0;
            victim_valid_q  <= 1'b0;
            fill_q          <= '0;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            mem_req_addr_q  <= '0;
            mem_req_wdata_q <= '0;
            hit_cnt_q       <= '0;
            miss_cnt_q      <= '0;
            wb_cnt_q        <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                vptr_q[s]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: if (req_valid && req_ready) begin
                    req_tag_q   <= req_addr[ADDR_WIDTH-1 -: TAG];
                    req_idx_q   <= req_addr[OFF +: IDX];
                    req_rw_q    <= req_rw;
                    req_wdata_q <= req_wdata;
                end
                StLookup: begin
                    if (hit) begin
                        resp_valid_q <= 1'b1;
                        hit_cnt_q    <= sat_inc(hit_cnt_q);
                        if (req_rw_q) begin
                            resp_data_q                 <= req_wdata_q;
                            dirty_q[req_idx_q][hit_way] <= 1'b1;
                        end else begin
                            resp_data_q <= data_mem[req_idx_q][hit_way];
                        end
                    end else begin
                        miss_cnt_q      <= sat_inc(miss_cnt_q);
                        victim_q        <= victim_way;
                        victim_valid_q  <= valid_q[req_idx_q][victim_way];
                        mem_req_wdata_q <= data_mem[req_idx_q][victim_way];
                        mem_req_addr_q  <= victim_dirty
                            ? {tag_mem[req_idx_q][victim_way], req_idx_q, {OFF{1'b0}}}
                            : {req_tag_q, req_idx_q, {OFF{1'b0}}};
                    end
                end
                StWb: if (mem_req_ready) begin
                    wb_cnt_q       <= sat_inc(wb_cnt_q);
                    mem_req_addr_q <= {req_tag_q, req_idx_q, {OFF{1'b0}}};
                end
                StWait: if (mem_resp_valid) fill_q <= mem_resp_data;
                StInstall: begin
                    resp_valid_q                 <= 1'b1;
                    resp_data_q                  <= req_rw_q ? req_wdata_q : fill_q;
                    valid_q[req_idx_q][victim_q] <= 1'b1;
                    dirty_q[req_idx_q][victim_q] <= req_rw_q;
                    // Only replacing a live line moves the round-robin pointer.
                    if (victim_valid_q) vptr_q[req_idx_q] <= vptr_q[req_idx_q] + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Tag/data arrays carry no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (state_q == StLookup && hit && req_rw_q) begin
            data_mem[req_idx_q][hit_way] <= req_wdata_q;
        end else if (state_q == StInstall) begin
            data_mem[req_idx_q][victim_q] <= req_rw_q ? req_wdata_q : fill_q;
            tag_mem[req_idx_q][victim_q]  <= req_tag_q;
        end
    end
endmodule
